// File: rtl/branch_resolver.sv
// End-of-execute branch/jump resolver with registered redirect and a bimodal BHT.
// Fetch reads the BHT combinationally; execute updates it for resolved conditional branches.
module branch_resolver #(
    parameter int         XLEN     = 32,
    parameter int         DEPTH    = 16,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            flush,
    input  logic [14:0]     op_data,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] r1,
    input  logic [XLEN-1:0] r2,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] PC,
    input  logic            pred_in,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            pred_taken,
    output logic            load,
    output logic [XLEN-1:0] PC_out,
    output logic            EQ,
    output logic            NE,
    output logic            LT,
    output logic            GE,
    output logic            misalign
);

    localparam int IDXW = $clog2(DEPTH);

    logic [1:0]      bht [DEPTH];
    logic [IDXW-1:0] fetch_idx;
    logic [IDXW-1:0] exec_idx;

    logic            is_jump;
    logic            is_jalr;
    logic            is_branch;
    logic            act;

    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] jmp_tgt;

    logic            cmp_eq;
    logic            cmp_lt_s;
    logic            cmp_lt_u;

    logic            cond_valid;
    logic            cond;
    logic            f_eq;
    logic            f_ne;
    logic            f_lt;
    logic            f_ge;

    logic            nxt_load;
    logic [XLEN-1:0] nxt_pc;
    logic            nxt_eq;
    logic            nxt_ne;
    logic            nxt_lt;
    logic            nxt_ge;
    logic            nxt_mis;
    logic            bht_upd;
    logic [1:0]      ctr_cur;
    logic [1:0]      ctr_next;

    assign fetch_idx  = fetch_pc[IDXW+1:2];
    assign exec_idx   = PC[IDXW+1:2];
    // Prediction shows the stored counter only; a same-cycle update is not bypassed.
    assign pred_taken = bht[fetch_idx][1];

    assign is_jump   = op_data[5];
    assign is_jalr   = op_data[5] & op_data[1];
    assign is_branch = op_data[4];
    assign act       = en & ~flush & (is_jump | is_branch);

    assign seq_pc   = PC + XLEN'(4);
    assign br_tgt   = PC + imm;
    assign jalr_sum = r1 + imm;
    assign jmp_tgt  = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : br_tgt;

    assign cmp_eq   = (r1 == r2);
    assign cmp_lt_s = ($signed(r1) < $signed(r2));
    assign cmp_lt_u = (r1 < r2);

    always_comb begin
        cond_valid = 1'b0;
        cond       = 1'b0;
        f_eq       = 1'b0;
        f_ne       = 1'b0;
        f_lt       = 1'b0;
        f_ge       = 1'b0;
        case (func3)
            3'b000: begin
                cond_valid = 1'b1;
                cond       = cmp_eq;
                f_eq       = cmp_eq;
            end
            3'b001: begin
                cond_valid = 1'b1;
                cond       = ~cmp_eq;
                f_ne       = ~cmp_eq;
            end
            3'b100: begin
                cond_valid = 1'b1;
                cond       = cmp_lt_s;
                f_lt       = cmp_lt_s;
            end
            3'b101: begin
                cond_valid = 1'b1;
                cond       = ~cmp_lt_s;
                f_ge       = ~cmp_lt_s;
            end
            3'b110: begin
                cond_valid = 1'b1;
                cond       = cmp_lt_u;
                f_lt       = cmp_lt_u;
            end
            3'b111: begin
                cond_valid = 1'b1;
                cond       = ~cmp_lt_u;
                f_ge       = ~cmp_lt_u;
            end
            default: ;
        endcase
    end

    always_comb begin
        nxt_load = 1'b0;
        nxt_pc   = PC_out;
        nxt_eq   = 1'b0;
        nxt_ne   = 1'b0;
        nxt_lt   = 1'b0;
        nxt_ge   = 1'b0;
        nxt_mis  = 1'b0;
        bht_upd  = 1'b0;
        if (act) begin
            if (is_jump) begin
                nxt_pc   = jmp_tgt;
                nxt_mis  = |jmp_tgt[1:0];
                nxt_load = ~(|jmp_tgt[1:0]);
            end else if (cond_valid) begin
                nxt_pc   = cond ? br_tgt : seq_pc;
                nxt_mis  = cond & (|br_tgt[1:0]);
                nxt_load = (cond ^ pred_in) & ~(cond & (|br_tgt[1:0]));
                nxt_eq   = f_eq;
                nxt_ne   = f_ne;
                nxt_lt   = f_lt;
                nxt_ge   = f_ge;
                bht_upd  = 1'b1;
            end else begin
                // Reserved conditions resolve not-taken: redirect only if fetch guessed taken.
                nxt_pc   = seq_pc;
                nxt_load = pred_in;
            end
        end
    end

    always_comb begin
        ctr_cur  = bht[exec_idx];
        ctr_next = ctr_cur;
        if (cond) begin
            if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
        end else begin
            if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load     <= 1'b0;
            PC_out   <= '0;
            EQ       <= 1'b0;
            NE       <= 1'b0;
            LT       <= 1'b0;
            GE       <= 1'b0;
            misalign <= 1'b0;
        end else begin
            load     <= nxt_load;
            PC_out   <= nxt_pc;
            EQ       <= nxt_eq;
            NE       <= nxt_ne;
            LT       <= nxt_lt;
            GE       <= nxt_ge;
            misalign <= nxt_mis;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) bht[i] <= CTR_INIT;
        end else if (bht_upd) begin
            bht[exec_idx] <= ctr_next;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{op_data[14:6], op_data[3:2], op_data[0],
                           fetch_pc[XLEN-1:IDXW+2], fetch_pc[1:0], jalr_sum[0]};

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: driver pushes reference results, negedge monitor compares.
module tb_branch_resolver;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        flush;
    logic [14:0] op_data;
    logic [2:0]  func3;
    logic [31:0] r1, r2, imm, PC, fetch_pc;
    logic        pred_in;
    logic        pred_taken, load, EQ, NE, LT, GE, misalign;
    logic [31:0] PC_out;

    branch_resolver #(.XLEN(32), .DEPTH(DEPTH), .CTR_INIT(2'b01)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .op_data(op_data),
        .func3(func3), .r1(r1), .r2(r2), .imm(imm), .PC(PC),
        .pred_in(pred_in), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
        .load(load), .PC_out(PC_out), .EQ(EQ), .NE(NE), .LT(LT), .GE(GE),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        load;
        logic [31:0] pc;
        logic        eq, ne, lt, ge, mis;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          m_bht[DEPTH];
    logic [31:0] m_pc;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] got, logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
        m_pc = 32'h0;
    endfunction

    // Drive one instruction slot (called at posedge+1), check the fetch lookup, queue the result.
    task automatic issue(input logic e, input logic f, input logic [14:0] op,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [31:0] pc, input logic pi,
                         input logic [31:0] fpc);
        exp_t        x;
        logic        taken;
        logic        valid;
        logic [31:0] tgt;
        int          idx;
        en = e; flush = f; op_data = op; func3 = f3; r1 = a; r2 = b;
        imm = im; PC = pc; pred_in = pi; fetch_pc = fpc;
        #1;
        chk("pred_taken", pred_taken, m_bht[int'((fpc >> 2) % DEPTH)] >= 2);
        x.cyc = cyc + 1; x.load = 0; x.pc = m_pc;
        x.eq = 0; x.ne = 0; x.lt = 0; x.ge = 0; x.mis = 0;
        if (e && !f && (op[5] || op[4])) begin
            if (op[5]) begin
                tgt = op[1] ? ((a + im) & 32'hFFFF_FFFE) : pc + im;
                x.pc   = tgt;
                x.mis  = (tgt % 4) != 0;
                x.load = !x.mis;
            end else begin
                valid = 1; taken = 0;
                case (f3)
                    3'd0: begin taken = (a == b); x.eq = taken; end
                    3'd1: begin taken = (a != b); x.ne = taken; end
                    3'd4: begin taken = ($signed(a) < $signed(b)); x.lt = taken; end
                    3'd5: begin taken = ($signed(a) >= $signed(b)); x.ge = taken; end
                    3'd6: begin taken = (a < b); x.lt = taken; end
                    3'd7: begin taken = (a >= b); x.ge = taken; end
                    default: valid = 0;
                endcase
                if (valid) begin
                    tgt    = taken ? pc + im : pc + 4;
                    x.pc   = tgt;
                    x.mis  = taken && ((tgt % 4) != 0);
                    x.load = (taken != pi) && !x.mis;
                    idx    = int'((pc >> 2) % DEPTH);
                    if (taken) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
                    else       m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
                end else begin
                    x.pc   = pc + 4;
                    x.load = pi;
                end
            end
            m_pc = x.pc;
        end
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                x = q.pop_front();
                chk("load", load, x.load);
                chk("PC_out", PC_out, x.pc);
                chk("flags", {EQ, NE, LT, GE}, {x.eq, x.ne, x.lt, x.ge});
                chk("misalign", misalign, x.mis);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [14:0] OP_JAL  = 15'h0020;
    localparam logic [14:0] OP_JALR = 15'h0022;
    localparam logic [14:0] OP_BR   = 15'h0010;
    localparam logic [14:0] OP_NONE = 15'h0000;

    logic [14:0] rop;
    logic [31:0] ra, rb, rim, rpc;
    int          sel;

    initial begin
        rst = 1'b0; en = 0; flush = 0; op_data = '0; func3 = '0;
        r1 = '0; r2 = '0; imm = '0; PC = '0; pred_in = 0; fetch_pc = '0;
        model_reset();
        #2;
        chk("reset_outputs", {load, PC_out, EQ, NE, LT, GE, misalign}, 38'h0);
        chk("reset_pred", pred_taken, 1'b0);
        #10 rst = 1'b1;
        @(posedge clk); #1;

        // Push a few counters up, then reset mid-run with a redirect pending.
        issue(1, 0, OP_BR, 3'd0, 32'd7, 32'd7, 32'h8, 32'h40, 0, 32'h40);
        issue(1, 0, OP_BR, 3'd0, 32'd7, 32'd7, 32'h8, 32'h40, 1, 32'h40);
        issue(1, 0, OP_BR, 3'd0, 32'd7, 32'd7, 32'h8, 32'h44, 0, 32'h44);
        issue(1, 0, OP_JAL, 3'd0, 32'd0, 32'd0, 32'h40, 32'h100, 0, 32'h40);
        chk("pre_reset_load", load, 1'b1);
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", {load, PC_out, EQ, NE, LT, GE, misalign}, 38'h0);
        q.delete();
        model_reset();
        en = 0;
        #1 rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++)
            issue(0, 0, OP_NONE, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 32'(i * 4));

        // Saturation at PC 0x40, then decay; 0x80 aliases the same entry.
        for (int i = 0; i < 3; i++)
            issue(1, 0, OP_BR, 3'd0, 32'd3, 32'd3, 32'h10, 32'h40, 0, 32'h40);
        for (int i = 0; i < 4; i++)
            issue(1, 0, OP_BR, 3'd0, 32'd3, 32'd4, 32'h10, 32'h40, 1, 32'h40);
        issue(0, 0, OP_NONE, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 32'h80);
        issue(1, 0, OP_BR, 3'd1, 32'd3, 32'd4, 32'h10, 32'h80, 0, 32'h80);
        issue(0, 0, OP_NONE, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 32'h40);

        // BEQ mispredicted, then correctly predicted.
        issue(1, 0, OP_BR, 3'd0, 32'd5, 32'd5, 32'h20, 32'h100, 0, 32'h0);
        issue(1, 0, OP_BR, 3'd0, 32'd5, 32'd5, 32'h20, 32'h100, 1, 32'h0);

        // Signed vs unsigned on the same operands.
        issue(1, 0, OP_BR, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h200, 0, 32'h200);
        issue(1, 0, OP_BR, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h200, 1, 32'h200);
        issue(1, 0, OP_BR, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h200, 0, 32'h200);
        issue(1, 0, OP_BR, 3'd7, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h200, 0, 32'h200);
        issue(1, 0, OP_BR, 3'd5, 32'h8000_0000, 32'd1, 32'h40, 32'h200, 1, 32'h200);

        // JALR alignment handling, then idle hold of PC_out.
        issue(1, 0, OP_JALR, 3'd0, 32'h2003, 32'd0, 32'h0, 32'h300, 0, 32'h300);
        issue(1, 0, OP_JALR, 3'd0, 32'h2001, 32'd0, 32'h0, 32'h300, 0, 32'h300);
        issue(0, 0, OP_JAL, 3'd0, 32'd0, 32'd0, 32'h80, 32'h300, 0, 32'h300);

        // Flush kills a taken branch; reserved func3 with pred_in set.
        issue(1, 1, OP_BR, 3'd0, 32'd9, 32'd9, 32'h10, 32'h40, 0, 32'h40);
        issue(1, 0, OP_BR, 3'd2, 32'd9, 32'd9, 32'h10, 32'h40, 1, 32'h40);
        issue(1, 0, OP_BR, 3'd3, 32'd9, 32'd9, 32'h10, 32'h40, 0, 32'h40);
        // Misaligned taken branch still trains; wrap-around target.
        issue(1, 0, OP_BR, 3'd0, 32'd1, 32'd1, 32'h6, 32'h40, 0, 32'h40);
        issue(1, 0, OP_JAL, 3'd0, 32'd0, 32'd0, 32'h20, 32'hFFFF_FFF0, 0, 32'h40);

        for (int i = 0; i < 400; i++) begin
            rop = 15'($urandom);
            sel = $urandom_range(0, 9);
            if (sel < 2)      begin rop[5] = 1; rop[1] = 0; end
            else if (sel < 3) begin rop[5] = 1; rop[1] = 1; end
            else if (sel < 9) begin rop[5] = 0; rop[4] = 1; end
            else              begin rop[5] = 0; rop[4] = 0; end
            ra  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? ra :
                  (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7)) : $urandom);
            rim = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
            if ($urandom_range(0, 1) == 1) rim = -rim;
            rpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_01FC);
            issue($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, rop,
                  3'($urandom_range(0, 7)), ra, rb, rim, rpc, 1'($urandom_range(0, 1)),
                  $urandom & 32'h0000_00FF);
        end

        en = 0; flush = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Parametrised successor to the pipeline's combinational branch/jump address logic.
- Sits at the end of execute. Resolves JAL/JALR/conditional branches against a direction prediction supplied with the instruction, and registers the redirect request, target PC and comparison flags (one-cycle latency).
- Owns a DEPTH-entry bimodal branch history table (2-bit saturating counters) that fetch reads combinationally to predict direction.

Parameters:
- XLEN, 32, datapath width of operands, PC and immediate.
- DEPTH, 16, number of BHT entries (power of two, >=2); index = pc[IDXW+1:2], IDXW = log2(DEPTH).
- CTR_INIT, 2'b01, counter value on reset (weakly not-taken).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  instruction valid in execute this cycle.
- flush  in  1  kill the instruction in execute this cycle (no outputs, no BHT update).
- op_data  in  15  decoded opcode flags: bit5 = jump, bit1 (with bit5) = JALR, bit4 = conditional branch.
- func3  in  3  branch condition.
- r1, r2  in  XLEN  source operands.
- imm  in  XLEN  sign-extended immediate.
- PC  in  XLEN  PC of the instruction in execute.
- pred_in  in  1  predicted-taken bit carried down the pipe with the instruction.
- fetch_pc  in  XLEN  PC being fetched, used for BHT lookup.
- pred_taken  out  1  combinational: bht[fetch_pc index][1].
- load  out  1  registered redirect request to fetch.
- PC_out  out  XLEN  registered redirect target.
- EQ, NE, LT, GE  out  1 each  registered comparison flags.
- misalign  out  1  registered: taken target not 4-byte aligned.

Behaviour:
- Reset (rst low, any time, including mid-operation): load, PC_out, EQ, NE, LT, GE and misalign go to 0 immediately. Every BHT entry goes to CTR_INIT.
- act = en & ~flush & (op_data[5] | op_data[4]). All registered outputs update on the clk rising edge.
- When act is 0 at an edge: load and misalign are 0, flags are 0, PC_out holds its value, and the BHT is unchanged.
- Jump (op_data[5]; takes priority over op_data[4]):
  - Target is (r1+imm) with bit0 forced to 0 for JALR, otherwise PC+imm.
  - taken = 1. load = 1 unless misaligned. PC_out = target. Flags = 0. No BHT update.
- Branch conditions, by func3:
  - 000: EQ (r1==r2).
  - 001: NE.
  - 100: LT signed.
  - 101: GE signed.
  - 110: LT unsigned.
  - 111: GE unsigned.
  - 010 and 011: not taken, all flags 0, no BHT update, load = pred_in (redirect to PC+4 if it was mispredicted taken).
- Flag semantics: exactly the flag matching the evaluated condition is set to the condition result; all other flags are 0.
- Branch redirect:
  - PC_out = taken ? PC+imm : PC+4.
  - load = (taken != pred_in), i.e. redirect only on misprediction.
  - A correctly predicted branch gives load = 0, and PC_out is still written.
- misalign = taken & (target[1:0] != 0). When misalign = 1, load is forced to 0. The BHT still updates for branches.
- BHT update (valid conditional branches only): at the edge, the counter at the PC index is incremented if taken (saturating at 11) and decremented if not taken (saturating at 00).
- Same-cycle lookup and update to the same index: pred_taken shows the pre-update value, with no bypass.
- Arithmetic is modulo 2^XLEN. PC+imm wrap-around is legal and not flagged.
- flush asserted together with en: behaves as act = 0.

Test Plan:
- Reset: drive rst low mid-run with load = 1 pending -> all outputs 0 asynchronously; after release, pred_taken = 0 for every fetch_pc (CTR_INIT = 01).
- BEQ: PC=0x100, imm=0x20, r1=r2=5, pred_in=0 -> next edge load=1, PC_out=0x120, EQ=1. Repeat with pred_in=1 -> load=0, PC_out=0x120.
- Signed vs unsigned: r1=0xFFFFFFFF, r2=1 -> func3=100 gives LT=1 (taken); func3=110 gives LT=0, load=pred_in, PC_out=PC+4.
- JALR: r1=0x2003, imm=0 -> PC_out=0x2002, misalign=1, load=0. With r1=0x2001 -> PC_out=0x2000, load=1, misalign=0. BHT is unchanged in both cases.
- BHT saturation: three taken branches at PC=0x40 take the counter 01->10->11->11, and pred_taken for fetch_pc=0x40 becomes 1 after the first. Then four not-taken branches end at 00. fetch_pc=0x80 (same index, DEPTH=16) aliases and reads the same counter.
- Flush/hazard: branch with en=1, flush=1 -> load=0 and counter unchanged. Same-index lookup and update in one cycle -> pred_taken shows the old value, and the new value the following cycle.
